// File: rtl/tlram_responder.sv
// tlram_responder: TileLink-UL single-port SRAM responder.
//
// Accepts Get / PutFullData / PutPartialData on channel A, does one
// synchronous SRAM access per accepted beat and answers on channel D
// through a stage register (S1) followed by a 2-entry response FIFO.
//
// Optional feature macro: TLRAM_PARITY_EN
//   defined   -> one even-parity bit per byte is stored with each word;
//                a Get that sees a parity mismatch returns d_corrupt=1.
//   undefined -> no parity storage.
//
// Parameters:
//   TL_RS  source ID width
//   AW     byte-address width
//   DEPTH  number of 32-bit words (2 <= DEPTH <= 2**(AW-2))
//
// Ports:
//   tlram_clock_i / tlram_reset_ni       clock, async active-low reset
//   tlram_a_*                            channel A request (param ignored)
//   tlram_a_valid / tlram_a_ready        channel A handshake
//   tlram_d_*                            channel D response (head of FIFO)
//   tlram_d_valid / tlram_d_ready        channel D handshake
//
// Handshake: a beat transfers on a rising edge where valid & ready are
// both 1. valid never waits on ready; while valid & !ready the payload is
// held stable. a_ready is a flop and has no combinational path from any
// input; d_valid and d_* come straight from FIFO state.
module tlram_responder #(
   parameter int TL_RS = 4,
   parameter int AW    = 12,
   parameter int DEPTH = 1024
) (
   input  logic             tlram_clock_i,
   input  logic             tlram_reset_ni,
   input  logic [2:0]       tlram_a_opcode,
   input  logic [2:0]       tlram_a_param,
   input  logic [3:0]       tlram_a_size,
   input  logic [TL_RS-1:0] tlram_a_source,
   input  logic [AW-1:0]    tlram_a_address,
   input  logic [3:0]       tlram_a_mask,
   input  logic [31:0]      tlram_a_data,
   input  logic             tlram_a_corrupt,
   input  logic             tlram_a_valid,
   output logic             tlram_a_ready,
   output logic [2:0]       tlram_d_opcode,
   output logic [2:0]       tlram_d_param,
   output logic [3:0]       tlram_d_size,
   output logic [TL_RS-1:0] tlram_d_source,
   output logic             tlram_d_denied,
   output logic [31:0]      tlram_d_data,
   output logic             tlram_d_corrupt,
   output logic             tlram_d_valid,
   input  logic             tlram_d_ready
);

   localparam int IW = $clog2(DEPTH);

   localparam logic [2:0] OP_PUT_FULL = 3'd0;
   localparam logic [2:0] OP_PUT_PART = 3'd1;
   localparam logic [2:0] OP_GET      = 3'd4;
   localparam logic [2:0] OP_INTENT   = 3'd5;
   localparam logic [2:0] D_ACK       = 3'd0;
   localparam logic [2:0] D_ACK_DATA  = 3'd1;
   localparam logic [2:0] D_HINT_ACK  = 3'd2;

   logic unused_a_param;
   assign unused_a_param = ^tlram_a_param;

   // ---------------- request decode ----------------
   logic          a_fire, is_put, is_get, a_denied;
   logic          size_bad, align_bad, range_bad, op_bad;
   logic [AW-3:0] a_word;
   logic [IW-1:0] a_idx;
   logic [2:0]    resp_op;
   logic          mem_we, mem_re;
   logic          a_ready_q, a_ready_d;

   always_comb begin
      a_fire    = tlram_a_valid & a_ready_q;
      a_word    = tlram_a_address[AW-1:2];
      a_idx     = a_word[IW-1:0];
      is_put    = (tlram_a_opcode == OP_PUT_FULL) | (tlram_a_opcode == OP_PUT_PART);
      is_get    = (tlram_a_opcode == OP_GET);
      size_bad  = tlram_a_size > 4'd2;
      align_bad = ((tlram_a_size == 4'd1) & tlram_a_address[0]) |
                  ((tlram_a_size == 4'd2) & (tlram_a_address[1:0] != 2'b00));
      range_bad = 32'(a_word) >= 32'(DEPTH);
      op_bad    = tlram_a_opcode inside {3'd2, 3'd3, 3'd6, 3'd7};
      a_denied  = size_bad | align_bad | range_bad | op_bad | (is_put & tlram_a_corrupt);
      case (tlram_a_opcode)
         OP_GET, 3'd2, 3'd3: resp_op = D_ACK_DATA;
         OP_INTENT:          resp_op = D_HINT_ACK;
         default:            resp_op = D_ACK;
      endcase
      // Denied requests never touch the array, so an out-of-range index
      // (which would alias after truncation) is never used.
      mem_we = a_fire & is_put & ~a_denied;
      mem_re = a_fire & is_get & ~a_denied;
   end

   // ---------------- SRAM ----------------
   logic [31:0] mem [DEPTH];
   logic [31:0] rdata_q;
   logic        par_err;

   // Read port only enabled on a Get accept so rdata_q holds while S1 stalls.
   always_ff @(posedge tlram_clock_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (tlram_a_mask[b]) mem[a_idx][8*b +: 8] <= tlram_a_data[8*b +: 8];
         end
      end
      if (mem_re) rdata_q <= mem[a_idx];
   end

`ifdef TLRAM_PARITY_EN
   logic [3:0] par_mem [DEPTH];
   logic [3:0] rpar_q;

   always_ff @(posedge tlram_clock_i) begin
      if (mem_we) begin
         for (int b = 0; b < 4; b++) begin
            if (tlram_a_mask[b]) par_mem[a_idx][b] <= ^tlram_a_data[8*b +: 8];
         end
      end
      if (mem_re) rpar_q <= par_mem[a_idx];
   end

   always_comb begin
      par_err = 1'b0;
      for (int b = 0; b < 4; b++) begin
         if ((^rdata_q[8*b +: 8]) != rpar_q[b]) par_err = 1'b1;
      end
   end
`else
   assign par_err = 1'b0;
`endif

   // ---------------- S1 stage and response FIFO ----------------
   logic             s1_valid_q, s1_valid_d;
   logic [2:0]       s1_op_q, s1_op_d;
   logic [3:0]       s1_size_q, s1_size_d;
   logic [TL_RS-1:0] s1_src_q, s1_src_d;
   logic             s1_den_q, s1_den_d;
   logic             s1_cor_q, s1_cor_d;
   logic             s1_get_ok_q, s1_get_ok_d;
   logic [1:0]       count_q, count_d;
   logic             wptr_q, wptr_d, rptr_q, rptr_d;
   logic             d_valid_w, pop, s1_move;
   logic [31:0]      push_data;
   logic             push_cor;

   logic [2:0]       f_op   [2];
   logic [3:0]       f_size [2];
   logic [TL_RS-1:0] f_src  [2];
   logic             f_den  [2];
   logic             f_cor  [2];
   logic [31:0]      f_data [2];

   always_comb begin
      d_valid_w = (count_q != 2'd0);
      pop       = d_valid_w & tlram_d_ready;
      // A full FIFO still takes S1 when its head leaves on the same edge.
      s1_move   = s1_valid_q & ((count_q != 2'd2) | pop);
      push_data = s1_get_ok_q ? rdata_q : 32'h0;
      push_cor  = s1_cor_q | (s1_get_ok_q & par_err);

      s1_valid_d  = s1_valid_q;
      s1_op_d     = s1_op_q;
      s1_size_d   = s1_size_q;
      s1_src_d    = s1_src_q;
      s1_den_d    = s1_den_q;
      s1_cor_d    = s1_cor_q;
      s1_get_ok_d = s1_get_ok_q;
      if (a_fire) begin
         s1_valid_d  = 1'b1;
         s1_op_d     = resp_op;
         s1_size_d   = tlram_a_size;
         s1_src_d    = tlram_a_source;
         s1_den_d    = a_denied;
         s1_cor_d    = a_denied & (resp_op == D_ACK_DATA);
         s1_get_ok_d = is_get & ~a_denied;
      end else if (s1_move) begin
         s1_valid_d = 1'b0;
      end

      wptr_d    = wptr_q ^ s1_move;
      rptr_d    = rptr_q ^ pop;
      count_d   = count_q + {1'b0, s1_move} - {1'b0, pop};
      // Registered from next-state occupancy: at most 3 beats in flight.
      a_ready_d = ({2'b00, s1_valid_d} + {1'b0, count_d}) < 3'd3;
   end

   always_ff @(posedge tlram_clock_i or negedge tlram_reset_ni) begin
      if (!tlram_reset_ni) begin
         a_ready_q   <= 1'b1;
         s1_valid_q  <= 1'b0;
         s1_op_q     <= 3'd0;
         s1_size_q   <= 4'd0;
         s1_src_q    <= '0;
         s1_den_q    <= 1'b0;
         s1_cor_q    <= 1'b0;
         s1_get_ok_q <= 1'b0;
         count_q     <= 2'd0;
         wptr_q      <= 1'b0;
         rptr_q      <= 1'b0;
      end else begin
         a_ready_q   <= a_ready_d;
         s1_valid_q  <= s1_valid_d;
         s1_op_q     <= s1_op_d;
         s1_size_q   <= s1_size_d;
         s1_src_q    <= s1_src_d;
         s1_den_q    <= s1_den_d;
         s1_cor_q    <= s1_cor_d;
         s1_get_ok_q <= s1_get_ok_d;
         count_q     <= count_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
      end
   end

   // Entry storage carries no reset; outputs are gated by d_valid instead.
   always_ff @(posedge tlram_clock_i) begin
      if (s1_move) begin
         f_op[wptr_q]   <= s1_op_q;
         f_size[wptr_q] <= s1_size_q;
         f_src[wptr_q]  <= s1_src_q;
         f_den[wptr_q]  <= s1_den_q;
         f_cor[wptr_q]  <= push_cor;
         f_data[wptr_q] <= push_data;
      end
   end

   assign tlram_a_ready   = a_ready_q;
   assign tlram_d_valid   = d_valid_w;
   assign tlram_d_param   = 3'd0;
   assign tlram_d_opcode  = d_valid_w ? f_op[rptr_q]   : 3'd0;
   assign tlram_d_size    = d_valid_w ? f_size[rptr_q] : 4'd0;
   assign tlram_d_source  = d_valid_w ? f_src[rptr_q]  : '0;
   assign tlram_d_denied  = d_valid_w ? f_den[rptr_q]  : 1'b0;
   assign tlram_d_corrupt = d_valid_w ? f_cor[rptr_q]  : 1'b0;
   assign tlram_d_data    = d_valid_w ? f_data[rptr_q] : 32'h0;

endmodule

// File: tb/tb_tlram_responder.sv
// Testbench for tlram_responder. DEPTH is reduced to 512 so that a word
// index equal to DEPTH is addressable and the range check can be exercised.
module tb_tlram_responder;
   localparam int TL_RS = 4;
   localparam int AW    = 12;
   localparam int DEPTH = 512;
   localparam int W     = 48;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]       a_opcode = '0, a_param = '0;
   logic [3:0]       a_size = '0, a_mask = '0;
   logic [TL_RS-1:0] a_source = '0;
   logic [AW-1:0]    a_address = '0;
   logic [31:0]      a_data = '0;
   logic             a_corrupt = 1'b0, a_valid = 1'b0, d_ready = 1'b0;
   logic             a_ready, d_denied, d_corrupt, d_valid;
   logic [2:0]       d_opcode, d_param;
   logic [3:0]       d_size;
   logic [TL_RS-1:0] d_source;
   logic [31:0]      d_data;

   tlram_responder #(.TL_RS(TL_RS), .AW(AW), .DEPTH(DEPTH)) dut (
      .tlram_clock_i(clk), .tlram_reset_ni(rst_n),
      .tlram_a_opcode(a_opcode), .tlram_a_param(a_param), .tlram_a_size(a_size),
      .tlram_a_source(a_source), .tlram_a_address(a_address), .tlram_a_mask(a_mask),
      .tlram_a_data(a_data), .tlram_a_corrupt(a_corrupt), .tlram_a_valid(a_valid),
      .tlram_a_ready(a_ready), .tlram_d_opcode(d_opcode), .tlram_d_param(d_param),
      .tlram_d_size(d_size), .tlram_d_source(d_source), .tlram_d_denied(d_denied),
      .tlram_d_data(d_data), .tlram_d_corrupt(d_corrupt), .tlram_d_valid(d_valid),
      .tlram_d_ready(d_ready)
   );

   // ---------------- scoreboard state ----------------
   int            checks = 0;
   int            failures = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  obs_q[$];
   logic [31:0]   ref_mem [DEPTH];
   logic [3:0]    ref_par_bad [DEPTH];
   bit            rand_ready = 0;

   // Response layout: {opcode, param, size, source, denied, corrupt, data}
   function automatic logic [W-1:0] pack(input logic [2:0] op, input logic [3:0] sz,
                                         input logic [TL_RS-1:0] src, input logic den,
                                         input logic cor, input logic [31:0] data);
      return {op, 3'b000, sz, src, den, cor, data};
   endfunction

   // D beats are captured at negedge; d_ready only changes just after posedge.
   always @(negedge clk) begin
      if (rst_n && d_valid && d_ready)
         obs_q.push_back({d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data});
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_ready) d_ready = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation_time_exceeded got=timeout required=finish");
      $fatal(1);
   end

   // Reference model: evaluates one accepted request from the protocol rules.
   task automatic model_accept();
      int sz, addr, word;
      bit den;
      logic [2:0] rop;
      logic [31:0] data;
      logic cor;
      sz   = int'(a_size);
      addr = int'(a_address);
      word = addr / 4;
      den  = (sz > 2) || ((addr % (1 << sz)) != 0) || (word >= DEPTH) ||
             (a_opcode inside {3'd2, 3'd3, 3'd6, 3'd7}) || ((a_opcode <= 3'd1) && a_corrupt);
      case (a_opcode)
         3'd4, 3'd2, 3'd3: rop = 3'd1;
         3'd5:             rop = 3'd2;
         default:          rop = 3'd0;
      endcase
      data = 32'h0;
      cor  = den && (rop == 3'd1);
      if (a_opcode == 3'd4 && !den) begin
         data = ref_mem[word];
         if (ref_par_bad[word] != 4'd0) cor = 1'b1;
      end
      if (a_opcode <= 3'd1 && !den) begin
         for (int b = 0; b < 4; b++) begin
            if (a_mask[b]) begin
               ref_mem[word][8*b +: 8] = a_data[8*b +: 8];
               ref_par_bad[word][b] = 1'b0;
            end
         end
      end
      exp_q.push_back(pack(rop, a_size, a_source, den, cor, data));
   endtask

   // ---------------- driver tasks ----------------
   task automatic send(input logic [2:0] op, input logic [3:0] sz, input logic [TL_RS-1:0] src,
                       input logic [AW-1:0] addr, input logic [3:0] mask, input logic [31:0] data,
                       input logic cor, output int stalls);
      a_opcode = op; a_size = sz; a_source = src; a_address = addr;
      a_mask = mask; a_data = data; a_corrupt = cor; a_param = 3'($urandom);
      a_valid = 1'b1;
      stalls = 0;
      @(negedge clk);
      while (!a_ready && stalls < 200) begin
         stalls++;
         @(negedge clk);
      end
      checks++;
      if (a_ready) model_accept();
      else begin
         failures++;
         $display("FAIL send_timeout a_ready=%0b required=1 after %0d cycles", a_ready, stalls);
      end
      @(posedge clk);
      #1;
      a_valid = 1'b0;
   endtask

   task automatic pick_get();
      a_opcode = 3'd4; a_size = 4'd2; a_source = TL_RS'($urandom);
      a_address = AW'($urandom_range(0, 31) * 4); a_mask = 4'($urandom);
      a_data = $urandom; a_corrupt = 1'b0; a_param = 3'($urandom);
   endtask

   task automatic wait_obs(input int n, output bit ok);
      int t = 0;
      while (obs_q.size() < n && t < 500) begin
         @(posedge clk);
         t++;
      end
      repeat (3) @(posedge clk);
      #1;
      ok = (obs_q.size() >= n);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL reset_a_ready got=%b required=1", a_ready); end
      checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL reset_d_valid got=%b required=0", d_valid); end
      checks++;
      if ({d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data} !== '0) begin
         failures++;
         $display("FAIL reset_d_fields got=%h required=0", {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data});
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL post_reset_a_ready got=%b required=1", a_ready); end
      checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL post_reset_d_valid got=%b required=0", d_valid); end
   endtask

   task automatic test_put_get();
      int st;
      bit ok;
      logic [W-1:0] req [4];
      d_ready = 1'b1;
      send(3'd0, 4'd2, 4'd1, 12'h010, 4'hF, 32'hDEADBEEF, 1'b0, st);
      send(3'd4, 4'd2, 4'd2, 12'h010, 4'hF, $urandom, 1'b0, st);
      send(3'd1, 4'd2, 4'd3, 12'h010, 4'h2, 32'h0000AA00, 1'b0, st);
      send(3'd4, 4'd2, 4'd4, 12'h010, 4'hF, $urandom, 1'b0, st);
      req[0] = pack(3'd0, 4'd2, 4'd1, 1'b0, 1'b0, 32'h0);
      req[1] = pack(3'd1, 4'd2, 4'd2, 1'b0, 1'b0, 32'hDEADBEEF);
      req[2] = pack(3'd0, 4'd2, 4'd3, 1'b0, 1'b0, 32'h0);
      req[3] = pack(3'd1, 4'd2, 4'd4, 1'b0, 1'b0, 32'hDEADAAEF);
      wait_obs(4, ok);
      checks++;
      if (!ok || obs_q.size() != 4) begin failures++; $display("FAIL put_get_count got=%0d required=4", obs_q.size()); end
      for (int i = 0; i < 4; i++) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== req[i]) begin failures++; $display("FAIL put_get_resp[%0d] got=%h required=%h", i, obs_q[i], req[i]); end
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_latency();
      int st, n;
      bit ok;
      d_ready = 1'b1;
      send(3'd4, 4'd2, 4'd5, 12'h010, 4'hF, 32'h0, 1'b0, st);
      checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL latency_early d_valid=%b required=0", d_valid); end
      @(posedge clk);
      #1;
      checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL latency_valid d_valid=%b required=1", d_valid); end
      checks++; if (d_data !== 32'hDEADAAEF) begin failures++; $display("FAIL latency_data got=%h required=deadaaef", d_data); end
      n = exp_q.size();
      wait_obs(n, ok);
      checks++;
      if (!ok || obs_q.size() != n) begin failures++; $display("FAIL latency_count got=%0d required=%0d", obs_q.size(), n); end
      for (int i = 0; i < n; i++) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL latency_resp[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_denied();
      int st, n;
      bit ok;
      d_ready = 1'b1;
      send(3'd4, 4'd2, 4'd6, 12'h006, 4'hF, 32'h0, 1'b0, st);          // misaligned
      send(3'd4, 4'd3, 4'd7, 12'h010, 4'hF, 32'h0, 1'b0, st);          // size 3
      send(3'd4, 4'd2, 4'd8, 12'h800, 4'hF, 32'h0, 1'b0, st);          // word == DEPTH
      send(3'd0, 4'd2, 4'd9, 12'h810, 4'hF, 32'h12345678, 1'b0, st);   // out of range, aliases word 4
      send(3'd0, 4'd2, 4'd10, 12'h010, 4'hF, 32'h55555555, 1'b1, st);  // poisoned put
      send(3'd2, 4'd2, 4'd11, 12'h010, 4'hF, 32'h0, 1'b0, st);         // arithmetic
      send(3'd6, 4'd2, 4'd12, 12'h010, 4'hF, 32'h0, 1'b0, st);         // illegal opcode
      send(3'd5, 4'd2, 4'd13, 12'h014, 4'hF, 32'h0, 1'b0, st);         // intent
      send(3'd0, 4'd1, 4'd14, 12'h011, 4'h3, 32'hFFFFFFFF, 1'b0, st);  // misaligned half put
      send(3'd4, 4'd2, 4'd15, 12'h010, 4'hF, 32'h0, 1'b0, st);         // memory untouched
      n = exp_q.size();
      wait_obs(n, ok);
      checks++;
      if (!ok || obs_q.size() != n) begin failures++; $display("FAIL denied_count got=%0d required=%0d", obs_q.size(), n); end
      for (int i = 0; i < n; i++) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL denied_resp[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
         end
      end
      for (int i = 0; i < 3; i++) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i][47:45] !== 3'd1 || obs_q[i][33:32] !== 2'b11 || obs_q[i][31:0] !== 32'h0) begin
               failures++;
               $display("FAIL denied_get[%0d] got=%h required=op1 denied1 corrupt1 data0", i, obs_q[i]);
            end
         end
      end
      if (obs_q.size() == 10) begin
         checks++;
         if (obs_q[9][31:0] !== 32'hDEADAAEF) begin failures++; $display("FAIL denied_mem_unchanged got=%h required=deadaaef", obs_q[9][31:0]); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

`ifdef TLRAM_PARITY_EN
   task automatic test_parity();
      int st;
      bit ok;
      d_ready = 1'b1;
      dut.par_mem[4][0] = ~dut.par_mem[4][0];
      ref_par_bad[4][0] = 1'b1;
      send(3'd4, 4'd2, 4'd3, 12'h010, 4'hF, 32'h0, 1'b0, st);
      wait_obs(1, ok);
      checks++;
      if (!ok || obs_q.size() != 1) begin failures++; $display("FAIL parity_count got=%0d required=1", obs_q.size()); end
      else begin
         checks++;
         if (obs_q[0] !== pack(3'd1, 4'd2, 4'd3, 1'b0, 1'b1, 32'hDEADAAEF)) begin
            failures++;
            $display("FAIL parity_resp got=%h required=%h", obs_q[0], pack(3'd1, 4'd2, 4'd3, 1'b0, 1'b1, 32'hDEADAAEF));
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask
`endif

   task automatic test_random();
      int st, n, word, sz, addr, sel;
      bit ok;
      logic [2:0] op;
      d_ready = 1'b1;
      for (int w = 0; w < 32; w++) send(3'd0, 4'd2, TL_RS'($urandom), AW'(w * 4), 4'hF, $urandom, 1'b0, st);
      rand_ready = 1;
      for (int i = 0; i < 60; i++) begin
         sel = $urandom_range(0, 9);
         case (sel)
            0, 1:    op = 3'd0;
            2:       op = 3'd1;
            3, 4, 5: op = 3'd4;
            6:       op = 3'd2;
            7:       op = 3'd5;
            8:       op = 3'd6;
            default: op = 3'd3;
         endcase
         word = ($urandom_range(0, 9) == 0) ? DEPTH + int'($urandom_range(0, 7)) : int'($urandom_range(0, 31));
         sz   = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
         addr = word * 4 + (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
         send(op, 4'(sz), TL_RS'($urandom), AW'(addr), 4'($urandom), $urandom,
              1'($urandom_range(0, 7) == 0), st);
         repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      end
      rand_ready = 0;
      d_ready = 1'b1;
      n = exp_q.size();
      wait_obs(n, ok);
      checks++;
      if (!ok || obs_q.size() != n) begin failures++; $display("FAIL random_count got=%0d required=%0d", obs_q.size(), n); end
      for (int i = 0; i < n; i++) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL random_resp[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int st, stall_sum, n, w;
      bit ok;
      d_ready = 1'b1;
      stall_sum = 0;
      for (int i = 0; i < 20; i++) begin
         w = $urandom_range(0, 31);
         send(3'd0, 4'd2, TL_RS'($urandom), AW'(w * 4), 4'($urandom_range(1, 15)), $urandom, 1'b0, st);
         stall_sum += st;
         send(3'd4, 4'd2, TL_RS'($urandom), AW'(w * 4), 4'hF, 32'h0, 1'b0, st);
         stall_sum += st;
      end
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++; if (stall_sum != 0) begin failures++; $display("FAIL b2b_stalls got=%0d required=0", stall_sum); end
      checks++; if (obs_q.size() != 40) begin failures++; $display("FAIL b2b_rate got=%0d required=40", obs_q.size()); end
      n = exp_q.size();
      wait_obs(n, ok);
      checks++;
      if (!ok || obs_q.size() != n) begin failures++; $display("FAIL b2b_count got=%0d required=%0d", obs_q.size(), n); end
      for (int i = 0; i < n; i++) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_resp[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_backpressure();
      int acc, n;
      bit ok, took;
      logic [W-1:0] snap;
      d_ready = 1'b0;
      pick_get();
      a_valid = 1'b1;
      acc = 0;
      repeat (10) begin
         @(negedge clk);
         took = a_ready;
         if (took) begin model_accept(); acc++; end
         @(posedge clk);
         #1;
         if (took) pick_get();
      end
      a_valid = 1'b0;
      checks++; if (acc != 3) begin failures++; $display("FAIL bp_accepts got=%0d required=3", acc); end
      checks++; if (a_ready !== 1'b0) begin failures++; $display("FAIL bp_a_ready got=%b required=0", a_ready); end
      checks++; if (d_valid !== 1'b1) begin failures++; $display("FAIL bp_d_valid got=%b required=1", d_valid); end
      snap = {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data};
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data} !== snap) begin
         failures++;
         $display("FAIL bp_stable got=%h required=%h", {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt, d_data}, snap);
      end
      d_ready = 1'b1;
      n = exp_q.size();
      wait_obs(n, ok);
      checks++;
      if (!ok || obs_q.size() != n) begin failures++; $display("FAIL bp_count got=%0d required=%0d", obs_q.size(), n); end
      for (int i = 0; i < n; i++) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL bp_resp[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid();
      int st, n;
      bit ok;
      d_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(3'd4, 4'd2, TL_RS'(i), AW'(i * 4), 4'hF, 32'h0, 1'b0, st);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (d_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_d_valid got=%b required=0", d_valid); end
      checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_a_ready got=%b required=1", a_ready); end
      checks++; if (d_data !== 32'h0) begin failures++; $display("FAIL rst_mid_d_data got=%h required=0", d_data); end
      @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete(); obs_q.delete();
      d_ready = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL rst_mid_stale got=%0d required=0", obs_q.size()); end
      send(3'd4, 4'd2, 4'd9, 12'h010, 4'hF, 32'h0, 1'b0, st);
      n = exp_q.size();
      wait_obs(n, ok);
      checks++;
      if (!ok || obs_q.size() != n) begin failures++; $display("FAIL rst_mid_count got=%0d required=%0d", obs_q.size(), n); end
      for (int i = 0; i < n; i++) begin
         if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rst_mid_resp[%0d] got=%h required=%h", i, obs_q[i], exp_q[i]); end
         end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      for (int w = 0; w < DEPTH; w++) ref_par_bad[w] = 4'd0;
      test_reset();
      test_put_get();
      test_latency();
      test_denied();
`ifdef TLRAM_PARITY_EN
      test_parity();
`endif
      test_random();
      test_back_to_back();
      test_backpressure();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tlram_responder.md
# tlram_responder

TileLink-UL single-port SRAM responder, the memory-side endpoint for one DMA channel master port (`sa_*`/`sd_*`) or any other 32-bit TL-UL initiator in the fabric. It accepts Get, PutFullData and PutPartialData on channel A, performs a synchronous SRAM access, and returns AccessAck/AccessAckData on channel D through a 2-entry response queue. Throughput is one beat per cycle, and channel D backpressure is fully supported.

## Interface
- `TL_RS`, 4: source ID width.
- `AW`, 12: byte-address width on channel A.
- `DEPTH`, 1024: number of 32-bit words; must be ≤ 2^(AW-2).
- `tlram_clock_i` in 1: clock.
- `tlram_reset_ni` in 1: reset; one clock, asynchronous assert, active-low.
- `tlram_a_opcode` in 3: A opcode.
- `tlram_a_param` in 3: ignored.
- `tlram_a_size` in 4: log2 bytes.
- `tlram_a_source` in TL_RS: echoed on D.
- `tlram_a_address` in AW: byte address.
- `tlram_a_mask` in 4: byte lanes.
- `tlram_a_data` in 32: write data.
- `tlram_a_corrupt` in 1: write data poisoned.
- `tlram_a_valid` in 1, `tlram_a_ready` out 1: A handshake.
- `tlram_d_opcode` out 3, `tlram_d_param` out 3 (always 0), `tlram_d_size` out 4, `tlram_d_source` out TL_RS: D header fields.
- `tlram_d_denied` out 1, `tlram_d_data` out 32, `tlram_d_corrupt` out 1: D status and data.
- `tlram_d_valid` out 1, `tlram_d_ready` in 1: D handshake.

## Operation
- Accept occurs when `a_valid & a_ready` at a rising edge.
- On accept, the request is checked, the SRAM is accessed at word `a_address[AW-1:2]`, and the request metadata is loaded into stage register S1.
- Denied if any of the following holds; a denied request causes no SRAM write:
  - `a_size > 2`;
  - `a_address` is not aligned to 2^size;
  - word index ≥ DEPTH;
  - opcode is 2, 3, 6 or 7;
  - a Put arrives with `a_corrupt=1`.
- Response opcode mapping:
  - Get (4) → AccessAckData (1).
  - PutFull (0) and PutPartial (1) → AccessAck (0).
  - Arithmetic/Logical (2, 3) → AccessAckData (1), denied.
  - Intent (5) → HintAck (2), not denied, no SRAM access.
  - 6 and 7 → AccessAck (0), denied.
- Puts write only the lanes whose `a_mask` bit is set. PutFull masks are not cross-checked against size.
- `d_data` carries the full 32-bit SRAM word for a successful Get, and 0 otherwise.
- `d_corrupt` is 1 when denied with AccessAckData, and 0 for every AccessAck.
- `d_size` and `d_source` echo the request.
- The SRAM read port is enabled only on a Get accept, so its output holds while S1 stalls.
- S1 moves into the response FIFO when the FIFO is not full, or when it is full and a pop happens on the same edge.
- The FIFO is 2 entries; its head drives all `d_*` outputs.
- `a_ready = (S1_valid + fifo_count) < 3`. It is purely registered and has no combinational path from `d_ready`.
- A simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Read-after-write to the same word on consecutive accepts returns the new data.

## Timing
- Latency: accept at edge k makes the response visible on D after edge k+1. This is 2 edges with an idle D channel.
- Throughput: with `d_ready` held high, one response per cycle and `a_ready` stays 1.
- Backpressure: with `d_ready=0`, exactly 3 requests are accepted, then `a_ready` drops.
- `d_*` fields are stable while `d_valid & !d_ready`.
- Reset (async, active-low) takes effect immediately:
  - `a_ready=1` (after reset), `d_valid=0`.
  - All other `d_*` outputs are 0.
  - S1 and the FIFO are emptied.
  - SRAM contents are not reset.
- Reset mid-transfer drops all in-flight responses; no partial write is performed for requests not yet accepted.

## Configuration
- Macro `TLRAM_PARITY_EN`.
- Defined:
  - One even-parity bit per byte is stored alongside the data and written per masked lane.
  - On a Get, any byte whose parity mismatches forces `d_corrupt=1`; `d_denied` stays 0 and the data is returned unchanged.
  - Words never written may flag corrupt.
- Undefined:
  - No parity storage.
  - `d_corrupt` is asserted only for denied data responses.

## Test plan
- PutFull addr 0x10 data 0xDEADBEEF mask 0xF, then Get addr 0x10 size 2 → AccessAck, then AccessAckData 0xDEADBEEF, denied=0, corrupt=0, source echoed.
- PutPartial addr 0x10 mask 0x2 data 0x0000AA00 over 0xDEADBEEF, then Get → 0xDEADAAEF.
- Get size 2 addr 0x6 (misaligned), Get size 3, and Get at word DEPTH → each returns AccessAckData with denied=1, corrupt=1, data 0, and memory is unchanged.
- `d_ready=0` with a continuous A stream → exactly 3 accepts, then `a_ready=0`. Releasing `d_ready` drains the responses in order with no loss or duplication.
- Back-to-back Put then Get to the same word with `d_ready=1` → one response per cycle and the Get returns the new data.
- `TLRAM_PARITY_EN`: force-flip a stored parity bit, then Get → `d_corrupt=1`, `d_denied=0`.
